// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller.
//   fwd_sel_e    : operand-forward select encodings (register file, W stage, M stage)
//   wait_state_e : data-memory wait FSM states
//   hazard_t     : bundle of stall/flush controls driven to the pipeline
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hazard_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait tracker with timeout.
//   clk, rst  : clock, asynchronous active-low reset
//   i_req     : M-stage data-memory request
//   i_ack     : data-memory acknowledge
//   o_stall   : memory stall for this cycle (request outstanding, not acked)
//   o_err     : one-cycle pulse when the wait times out
// After a timeout the same request is ignored; a new stall can only start once
// the request has dropped for at least one cycle.
module mem_wait_fsm
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_ack,
  output logic o_stall,
  output logic o_err
);

  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // r_cnt is cleared in the IDLE cycle that raises the stall, so in WAIT
  // r_cnt+1 stall cycles have already elapsed; the error fires on the cycle
  // where TIMEOUT-1 stall cycles lie behind us.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

  wait_state_e   r_state;
  wait_state_e   w_next;
  logic [CW-1:0] r_cnt;
  logic          r_blk;
  logic          w_raw;
  logic          w_timeout;

  assign w_raw     = i_req & ~i_ack;
  assign w_timeout = (r_state == ST_WAIT) && w_raw && (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_raw && !r_blk)         w_next = ST_WAIT;
      ST_WAIT: if (!w_raw || w_timeout)     w_next = ST_IDLE;
      default:                              w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_stall = 1'b0;
    o_err   = 1'b0;
    case (r_state)
      ST_IDLE: o_stall = w_raw & ~r_blk;
      ST_WAIT: begin
        o_stall = w_raw & ~w_timeout;
        o_err   = w_timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_blk <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_cnt <= '0;
      else                    r_cnt <= r_cnt + 1'b1;
      if (w_timeout)   r_blk <= 1'b1;
      else if (!i_req) r_blk <= 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a five-stage pipeline.
//   clk, rst                 : clock, asynchronous active-low reset
//   Rs1_D, Rs2_D             : decode-stage source registers
//   Rs1_E, Rs2_E, RD_E       : execute-stage sources / destination
//   ResultSrcE, PCSrcE       : E-stage load flag, taken branch
//   RegWriteM/W, RD_M/W      : writeback info of M and W stages
//   MemReqM, MemAckM         : data-memory handshake
//   ForwardAE, ForwardBE     : operand-forward selects
//   StallF..StallM, FlushD/E/W : pipeline control
//   MemErr                   : memory-timeout pulse
//   StallCnt, FlushCnt       : saturating counts of StallF / FlushD cycles
// Priority: memory stall > taken branch > load-use stall.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              MemReqM,
  input  logic              MemAckM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  // M stage holds the newer value, so it wins over W; x0 is never forwarded.
  function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] rs);
    if (RegWriteM && (RD_M != '0) && (RD_M == rs))      return FWD_M;
    else if (RegWriteW && (RD_W != '0) && (RD_W == rs)) return FWD_W;
    else                                                return FWD_REG;
  endfunction

  fwd_sel_e         w_fwd_a;
  fwd_sel_e         w_fwd_b;
  logic             w_lw_stall;
  logic             w_mem_stall;
  logic             w_mem_err;
  hazard_t          w_haz;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_fwd_a    = fwd_sel(Rs1_E);
  assign w_fwd_b    = fwd_sel(Rs2_E);
  assign w_lw_stall = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  mem_wait_fsm #(.TIMEOUT(TIMEOUT)) u_mem_wait (
    .clk     (clk),
    .rst     (rst),
    .i_req   (MemReqM),
    .i_ack   (MemAckM),
    .o_stall (w_mem_stall),
    .o_err   (w_mem_err)
  );

  always_comb begin
    w_haz = '0;
    if (w_mem_stall) begin
      w_haz.stall_f = 1'b1;
      w_haz.stall_d = 1'b1;
      w_haz.stall_e = 1'b1;
      w_haz.stall_m = 1'b1;
      w_haz.flush_w = 1'b1;
    end else if (PCSrcE) begin
      w_haz.flush_d = 1'b1;
      w_haz.flush_e = 1'b1;
    end else if (w_lw_stall) begin
      w_haz.stall_f = 1'b1;
      w_haz.stall_d = 1'b1;
      w_haz.flush_e = 1'b1;
    end
  end

  // Outputs are combinational from live inputs, so they are forced quiet
  // while reset is asserted.
  assign ForwardAE = rst ? w_fwd_a : FWD_REG;
  assign ForwardBE = rst ? w_fwd_b : FWD_REG;
  assign StallF    = rst & w_haz.stall_f;
  assign StallD    = rst & w_haz.stall_d;
  assign StallE    = rst & w_haz.stall_e;
  assign StallM    = rst & w_haz.stall_m;
  assign FlushD    = rst & w_haz.flush_d;
  assign FlushE    = rst & w_haz.flush_e;
  assign FlushW    = rst & w_haz.flush_w;
  assign MemErr    = rst & w_mem_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (FlushD && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, perf-counter width.
REQ-003 SHALL have parameter TIMEOUT, default 64, max data-memory wait cycles before error.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports Rs1_D, Rs2_D  in  REG_AW  decode-stage source registers.
REQ-007 SHALL have ports Rs1_E, Rs2_E, RD_E  in  REG_AW  execute-stage sources/destination.
REQ-008 SHALL have ports ResultSrcE, PCSrcE  in  1  E-stage load flag, taken branch.
REQ-009 SHALL have ports RegWriteM, RegWriteW  in  1; RD_M, RD_W  in  REG_AW.
REQ-010 SHALL have ports MemReqM, MemAckM  in  1  data-memory request/acknowledge.
REQ-011 SHALL have ports ForwardAE, ForwardBE  out  2  operand-forward selects.
REQ-012 SHALL have ports StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW  out  1.
REQ-013 SHALL have port MemErr  out  1  one-cycle memory-timeout pulse.
REQ-014 SHALL have ports StallCnt, FlushCnt  out  CNT_W  saturating perf counters.

Function
REQ-015 ForwardAE SHALL be 2'b10 when RegWriteM, RD_M!=0, RD_M==Rs1_E; else 2'b01 when RegWriteW, RD_W!=0, RD_W==Rs1_E; else 2'b00 (M wins over W).
REQ-016 ForwardBE SHALL follow REQ-015 using Rs2_E.
REQ-017 lw_stall SHALL be ResultSrcE & RD_E!=0 & (RD_E==Rs1_D | RD_E==Rs2_D).
REQ-018 mem_stall SHALL be MemReqM & !MemAckM, combinational, same cycle.
REQ-019 When mem_stall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0, regardless of lw_stall or PCSrcE.
REQ-020 Else when PCSrcE: FlushD=FlushE=1, StallF=StallD=0 (branch flush overrides load-use stall).
REQ-021 Else when lw_stall: StallF=StallD=1, FlushE=1, FlushD=0.
REQ-022 Otherwise all stall/flush outputs SHALL be 0; StallE, StallM, FlushW only from REQ-019.
REQ-023 FSM states IDLE, WAIT; IDLE->WAIT on mem_stall; WAIT->IDLE on MemAckM or timeout.
REQ-024 Wait counter SHALL clear on entry to WAIT, increment each WAIT cycle; at count TIMEOUT-1 without ack: MemErr=1 for one cycle, FSM->IDLE, stalls drop that cycle.
REQ-025 After timeout, stall SHALL resume only after MemReqM deasserts for at least one cycle.
REQ-026 Ack in same cycle as request SHALL produce zero stall cycles.
REQ-027 StallCnt SHALL increment each cycle StallF=1; FlushCnt each cycle FlushD=1; both saturate at all-ones.
REQ-028 Forwarding outputs SHALL stay valid during stalls.

Reset
REQ-029 While rst=0: FSM=IDLE, wait counter=0, MemErr=0, StallCnt=FlushCnt=0.
REQ-030 While rst=0: all stall/flush outputs 0, ForwardAE=ForwardBE=2'b00.
REQ-031 Reset mid-WAIT SHALL abort immediately with no MemErr pulse.

Structure
REQ-032 Forward-select encodings (00 reg, 01 W, 10 M) and FSM state encodings SHALL reside in shared package pipeline_pkg.
REQ-033 Timeout/wait FSM SHALL be sub-module mem_wait_fsm; forwarding and priority logic stay in pipeline_ctrl.

Verification
REQ-034 RD_M=5, RegWriteM=1, RD_W=5, RegWriteW=1, Rs1_E=5 -> ForwardAE=10; RD_W=0, Rs2_E=0 -> ForwardBE=00.
REQ-035 ResultSrcE=1, RD_E=3, Rs2_D=3, PCSrcE=0 -> StallF=StallD=FlushE=1, FlushD=0, StallCnt +1.
REQ-036 Same as 035 with PCSrcE=1 -> FlushD=FlushE=1, StallF=0, FlushCnt +1.
REQ-037 MemReqM=1, ack after 3 cycles, PCSrcE=1 throughout -> StallM=1 for 3 cycles, FlushD=0 then, FlushD=1 on ack cycle.
REQ-038 MemReqM=1, never acked, TIMEOUT=4 -> MemErr high on 4th cycle, stalls low that cycle; rst=0 mid-wait in repeat run -> no MemErr, counters 0.
